// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer driving one external combinational 1-bit full adder, LSB first.
// Optional two's-complement overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             a,
  output logic             b,
  output logic             ci,
  input  logic             sum,
  input  logic             co
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sa_d    = op_a;
          sb_d    = op_b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StShift;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      StShift: begin
        result_d = {sum, result_q[WIDTH-1:1]};
        carry_d  = co;
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          cout_d  = co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on this final edge
          ovf_d   = carry_q ^ co;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // busy_q is high exactly in SHIFT, so it gates the adder inputs to 0 elsewhere
  assign a      = busy_q & sa_q[0];
  assign b      = busy_q & sb_q[0];
  assign ci     = busy_q & carry_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a delayed gate-level full adder model.
// Overflow checks are active when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] op_a, op_b;
  logic             cin;
  logic             busy, done, cout;
  logic [WIDTH-1:0] result;
  logic             a_w, b_w, ci_w;
  wire              sum_w, co_w;
  wire              p_w, g_w;
  logic             ovf;

  int n_cmp = 0;
  int n_err = 0;
  int lo_t  = 5;
  int hi_t  = 5;

  always begin
    #(lo_t) clk = 1'b1;
    #(hi_t) clk = 1'b0;
  end

  // Two gate levels of 2 time units each: 4 units worst case
  assign #2 p_w   = a_w ^ b_w;
  assign #2 g_w   = a_w & b_w;
  assign #2 sum_w = p_w ^ ci_w;
  assign #2 co_w  = g_w | (p_w & ci_w);

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf    (ovf),
`endif
    .a      (a_w),
    .b      (b_w),
    .ci     (ci_w),
    .sum    (sum_w),
    .co     (co_w)
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf = 1'b0;
`endif

  task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                        output logic [7:0] r, output logic rc, output logic rv,
                        output int lat);
    @(negedge clk);
    op_a = xa; op_b = xb; cin = xc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 2 * WIDTH + 4) begin
      @(negedge clk);
      lat++;
    end
    r = result; rc = cout; rv = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    #3;
    n_cmp++;
    if ({busy, done, cout, a_w, b_w, ci_w, result} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, want all zero",
               {busy, done, cout, a_w, b_w, ci_w, result});
    end
`ifdef SERIAL_ADD_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b, want 0", ovf); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] sa, sb;
    bit early_done, not_busy;
    early_done = 0; not_busy = 0;
    @(negedge clk);
    op_a = 8'h35; op_b = 8'h4A; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      sa[k] = a_w; sb[k] = b_w;
      if (done !== 1'b0) early_done = 1;
      if (busy !== 1'b1) not_busy = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (sa !== 8'h35 || sb !== 8'h4A) begin
      n_err++; $display("FAIL basic_bit_seq: got a=%h b=%h, want a=35 b=4a", sa, sb);
    end
    n_cmp++;
    if (early_done || not_busy) begin
      n_err++; $display("FAIL basic_shift_flags: early_done=%0d not_busy=%0d, want 0 0",
                        early_done, not_busy);
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_done_edge: done=%b busy=%b, want 1 0", done, busy);
    end
    n_cmp++;
    if (result !== 8'h7F || cout !== 1'b0) begin
      n_err++; $display("FAIL basic_result: got %b_%h, want 0_7f", cout, result);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || result !== 8'h7F) begin
      n_err++; $display("FAIL basic_after_done: done=%b result=%h, want 0 7f", done, result);
    end
  endtask

  task automatic test_carry();
    logic [7:0] cis;
    @(negedge clk);
    op_a = 8'hFF; op_b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      cis[k] = ci_w;
      @(negedge clk);
    end
    n_cmp++;
    if (cis !== 8'hFE) begin n_err++; $display("FAIL carry_ci_seq: got %b, want 11111110", cis); end
    n_cmp++;
    if (done !== 1'b1 || result !== 8'h00 || cout !== 1'b1) begin
      n_err++; $display("FAIL carry_result: done=%b got %b_%h, want 1 1_00", done, cout, result);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL carry_ovf: got %b, want 0", ovf); end
`endif
  endtask

  task automatic test_ovf();
    logic [7:0] r; logic rc, rv; int lat;
    run_op(8'h7F, 8'h00, 1'b1, r, rc, rv, lat);
    n_cmp++;
    if (r !== 8'h80 || rc !== 1'b0 || lat != WIDTH + 1) begin
      n_err++; $display("FAIL ovf_result: got %b_%h lat %0d, want 0_80 lat %0d", rc, r, lat,
                        WIDTH + 1);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_cmp++;
    if (rv !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b, want 1", rv); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] r; logic rc, rv; int lat;
    @(negedge clk);
    op_a = 8'h10; op_b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    op_a = 8'hAA; op_b = 8'h55; start = 1'b1;  // sampled at E3
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (done !== 1'b1 && lat < 2 * WIDTH + 4) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != WIDTH + 1 || result !== 8'h30) begin
      n_err++; $display("FAIL b2b_first: lat %0d result %h, want lat %0d result 30", lat, result,
                        WIDTH + 1);
    end
    start = 1'b1;  // sampled in DONE, then again in the following IDLE cycle
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h30) begin
      n_err++; $display("FAIL b2b_done_ignore: busy=%b done=%b result=%h, want 0 0 30",
                        busy, done, result);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_idle_accept: busy=%b, want 1", busy); end
    lat = 1;
    while (done !== 1'b1 && lat < 2 * WIDTH + 4) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (result !== 8'hFF || cout !== 1'b0 || lat != WIDTH + 1) begin
      n_err++; $display("FAIL b2b_second: got %b_%h lat %0d, want 0_ff lat %0d", cout, result,
                        lat, WIDTH + 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r; logic rc, rv; int lat;
    bit saw_done;
    saw_done = 0;
    @(negedge clk);
    op_a = 8'h12; op_b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, cout, a_w, b_w, ci_w, result, ovf} !== '0) begin
      n_err++; $display("FAIL rst_mid_outputs: got %b, want all zero",
                        {busy, done, cout, a_w, b_w, ci_w, result, ovf});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (saw_done) begin n_err++; $display("FAIL rst_mid_no_done: activity seen=1, want 0"); end
    run_op(8'h12, 8'h34, 1'b0, r, rc, rv, lat);
    n_cmp++;
    if (r !== 8'h46 || rc !== 1'b0 || lat != WIDTH + 1) begin
      n_err++; $display("FAIL rst_mid_fresh: got %b_%h lat %0d, want 0_46 lat %0d", rc, r, lat,
                        WIDTH + 1);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] xa, xb, r, er; logic xc, rc, rv, ec, ev; int lat; int bad;
    logic [8:0] full;
    for (int i = 0; i < 1000; i++) begin
      xa = 8'($urandom_range(0, 255)); xb = 8'($urandom_range(0, 255));
      xc = 1'($urandom_range(0, 1));
      full = {1'b0, xa} + {1'b0, xb} + {8'b0, xc};
      er = full[7:0]; ec = full[8];
`ifdef SERIAL_ADD_OVF_EN
      ev = (xa[7] == xb[7]) && (er[7] != xa[7]);
`else
      ev = 1'b0;
`endif
      run_op(xa, xb, xc, r, rc, rv, lat);
      n_cmp++;
      if (r !== er || rc !== ec || rv !== ev || lat != WIDTH + 1) begin
        n_err++;
        $display("FAIL sweep10_op%0d: %h+%h+%b got %b_%h v%b lat %0d, want %b_%h v%b lat %0d",
                 i, xa, xb, xc, rc, r, rv, lat, ec, er, ev, WIDTH + 1);
      end
    end
    // 3-unit period is shorter than the 4-unit adder settle time
    lo_t = 1; hi_t = 2;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      xa = 8'($urandom_range(0, 255)); xb = 8'($urandom_range(0, 255));
      xc = 1'($urandom_range(0, 1));
      full = {1'b0, xa} + {1'b0, xb} + {8'b0, xc};
      run_op(xa, xb, xc, r, rc, rv, lat);
      if ({rc, r} !== full) bad++;
    end
    n_cmp++;
    if (bad == 0) begin
      n_err++; $display("FAIL sweep3_settle: wrong results %0d, want at least 1", bad);
    end
    lo_t = 5; hi_t = 5;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
